ioctl_loader: RTL

Synthesizable multi-channel download engine between the HPS `ioctl_*` stream and the SDRAM controller write port. Selects a per-channel destination region from `ioctl_index`, applies per-channel byte swap and bounds checking, and buffers words in a FIFO. Asserts `ioctl_wait` as backpressure. Replaces the behavioural file loader with a path usable in hardware for BIOS, cart and RAM images.

---
 rtl/ioctl_loader_pkg.sv | 39 +++
 rtl/ioctl_loader_if.sv | 27 ++
 rtl/ioctl_loader_fifo.sv | 58 +++++
 rtl/ioctl_loader.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the ioctl download engine: FIFO entry layout,
// FSM encodings and default channel regions for BIOS, cartridge and RAM images.
package ioctl_loader_pkg;

    localparam int LOADER_ADDR_W = 25;
    localparam int LOADER_DW     = 16;

    localparam int LOADER_CH_BIOS = 0;
    localparam int LOADER_CH_CART = 1;
    localparam int LOADER_CH_RAM  = 2;

    localparam logic [LOADER_ADDR_W-1:0] LOADER_BASE_BIOS = 25'h0000000;
    localparam logic [LOADER_ADDR_W-1:0] LOADER_SIZE_BIOS = 25'h0080000;
    localparam logic [LOADER_ADDR_W-1:0] LOADER_BASE_CART = 25'h0800000;
    localparam logic [LOADER_ADDR_W-1:0] LOADER_SIZE_CART = 25'h0800000;
    localparam logic [LOADER_ADDR_W-1:0] LOADER_BASE_RAM  = 25'h1000000;
    localparam logic [LOADER_ADDR_W-1:0] LOADER_SIZE_RAM  = 25'h1000000;

    typedef struct packed {
        logic [LOADER_ADDR_W-1:0] addr;
        logic [LOADER_DW-1:0]     data;
    } loader_ent_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_REQ
    } drain_state_t;

    typedef enum logic [1:0] {
        CMPL_OFF,
        CMPL_LOAD,
        CMPL_FLUSH
    } cmpl_state_t;

    function automatic logic [LOADER_DW-1:0] swap_bytes(input logic [LOADER_DW-1:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/ioctl_loader_if.sv
// Bundles the HPS ioctl stream and the SDRAM write port seen by the loader.
// The loader uses the slave view; the host/SDRAM side uses the master view.
interface ioctl_loader_if #(
    parameter int ADDR_W = 25,
    parameter int DW     = 16
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [DW-1:0]     ioctl_dout;
    logic              ioctl_wait;
    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic [DW-1:0]     ram_din;
    logic              ram_ack;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ram_ack,
        input  ioctl_wait, ram_req, ram_addr, ram_din
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ram_ack,
        output ioctl_wait, ram_req, ram_addr, ram_din
    );
endinterface

// File: rtl/ioctl_loader_fifo.sv
// Show-ahead FIFO: the head entry is readable without a pop, so the drain side
// can present it on the SDRAM port in the cycle after it was written.
module loader_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ioctl_loader.sv
// Multi-channel HPS download engine: maps ioctl writes into per-channel SDRAM
// regions, buffers them in a FIFO and drains them through the SDRAM write port.
module ioctl_loader
    import ioctl_loader_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = LOADER_ADDR_W,
    parameter int DW         = LOADER_DW
) (
    input  logic              clk_sys,
    input  logic              reset,
    ioctl_loader_if.slave     bus,
    input  logic [ADDR_W-1:0] ch_base [NUM_CH],
    input  logic [ADDR_W-1:0] ch_size [NUM_CH],
    input  logic              ch_swap [NUM_CH],
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = $bits(loader_ent_t);

    logic [5:0]       ch;
    logic [CH_W-1:0]  ch_sel;
    logic             ch_ok, in_range, wr_en, push, pop, bad;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count, count_next;
    logic [ENT_W-1:0] head_raw;
    loader_ent_t      push_ent, head_ent;
    logic [DW-1:0]    dout_sw;
    logic             dl_rise, dl_fall;
    logic             unused_bits;

    drain_state_t drain_q, drain_d;
    cmpl_state_t  cmpl_q, cmpl_d;
    logic         wait_q, wait_d, done_q, done_d, err_q, err_d, dl_prev_q, dl_prev_d;

    assign ch          = bus.ioctl_index[5:0];
    assign ch_sel      = ch[CH_W-1:0];
    assign ch_ok       = (32'(ch) < NUM_CH);
    assign in_range    = (bus.ioctl_addr < ch_size[ch_sel]);
    assign wr_en       = bus.ioctl_download & bus.ioctl_wr;
    // Full-FIFO pushes are dropped even when a pop lands in the same cycle.
    assign push        = wr_en & ch_ok & in_range & ~fifo_full;
    assign bad         = wr_en & ~(ch_ok & in_range & ~fifo_full);
    assign pop         = (drain_q == DRAIN_REQ) & bus.ram_ack;
    assign count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign dout_sw     = ch_swap[ch_sel] ? swap_bytes(bus.ioctl_dout) : bus.ioctl_dout;
    assign unused_bits = ^{bus.ioctl_index[7:6], bus.ioctl_addr[0]};

    always_comb begin
        push_ent.addr = ch_base[ch_sel] + {bus.ioctl_addr[24:1], 1'b0};
        push_ent.data = dout_sw;
    end

    loader_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys),
        .srst      (reset),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head_raw),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_ent = head_raw;

    // Drain: stay in REQ across pops while entries remain, giving one word per cycle.
    always_comb begin
        drain_d = drain_q;
        case (drain_q)
            DRAIN_IDLE: if (!fifo_empty) drain_d = DRAIN_REQ;
            DRAIN_REQ:  if (pop && count_next == '0) drain_d = DRAIN_IDLE;
            default:    drain_d = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        cmpl_d    = cmpl_q;
        done_d    = 1'b0;
        err_d     = err_q;
        dl_prev_d = bus.ioctl_download;
        dl_rise   = bus.ioctl_download & ~dl_prev_q;
        dl_fall   = ~bus.ioctl_download & dl_prev_q;
        wait_d    = (count_next >= CNT_W'(FIFO_DEPTH - 1));
        case (cmpl_q)
            CMPL_OFF:  if (dl_rise) cmpl_d = CMPL_LOAD;
            CMPL_LOAD: if (dl_fall) cmpl_d = CMPL_FLUSH;
            CMPL_FLUSH: begin
                if (dl_rise) begin
                    cmpl_d = CMPL_LOAD;
                end else if (fifo_empty && drain_q == DRAIN_IDLE) begin
                    done_d = 1'b1;
                    cmpl_d = CMPL_OFF;
                end
            end
            default: cmpl_d = CMPL_OFF;
        endcase
        if (dl_rise) err_d = 1'b0;
        if (bad)     err_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            drain_q   <= DRAIN_IDLE;
            cmpl_q    <= CMPL_OFF;
            wait_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dl_prev_q <= 1'b0;
        end else begin
            drain_q   <= drain_d;
            cmpl_q    <= cmpl_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dl_prev_q <= dl_prev_d;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.ram_req    = (drain_q == DRAIN_REQ);
    assign bus.ram_addr   = bus.ram_req ? head_ent.addr : '0;
    assign bus.ram_din    = bus.ram_req ? head_ent.data : '0;
    assign busy           = (cmpl_q != CMPL_OFF);
    assign done           = done_q;
    assign err            = err_q;

endmodule
